mult_seq_param: RTL and testbench

- Parameterised shift-add sequential multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product.
- Runtime-selectable unsigned or signed (two's complement) operation.
- start/busy/done handshake; one multiplier bit is retired per clock.
- Drop-in successor to the fixed 4x4 sequential multiplier in the arithmetic datapath. Adds width generality, signed mode, a busy flag and back-to-back operation.

---
 rtl/mult_seq_param_if.sv | 25 ++
 rtl/mult_seq_param.sv | 88 ++++++++
 tb/tb_mult_seq_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_param_if.sv
// Operand/result bundle for the sequential multiplier: requester drives start and
// operands, the multiplier answers with busy, a one-cycle done pulse and the product.
interface mult_seq_param_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  // start is honoured only on an edge where busy is low; done is high for exactly
  // one cycle and product is valid from that cycle until the next done.
  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq_param.sv
// Shift-add multiplier retiring one multiplier bit per clock; signed mode works on
// magnitudes and negates the accumulated result when the operand signs differ.
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_seq_param_if.slave     bus,
  output logic [1:0]          o_state
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_product;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  assign w_mag_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_RUN;
      S_RUN:    if (r_cnt == CW'(1)) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
        end
        S_FINISH: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign o_state     = r_state;
endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param at WIDTH=4 and WIDTH=8: table-driven 4-bit vectors plus
// hand-written back-to-back, ignored-start and reset-abort sequences.
module tb_mult_seq_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_param_if #(.WIDTH(4)) bus4 ();
  mult_seq_param_if #(.WIDTH(8)) bus8 ();
  logic [1:0] st4;
  logic [1:0] st8;

  mult_seq_param #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave), .o_state(st4));
  mult_seq_param #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave), .o_state(st8));

  typedef struct {
    logic       sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec4_t;

  vec4_t       v4[9];
  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];
  logic [7:0]  last4 = '0;
  logic [15:0] last8 = '0;
  int n_cmp = 0;
  int n_err = 0;
  int done4_cnt = 0;
  int done8_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (bus4.done === 1'b1) begin
      done4_cnt++;
      if (exp4_q.size() == 0) check("done4_unexpected", 64'(1), 64'(0));
      else check("prod4", 64'(bus4.product), 64'(exp4_q.pop_front()));
    end
    if (bus8.done === 1'b1) begin
      done8_cnt++;
      if (exp8_q.size() == 0) check("done8_unexpected", 64'(1), 64'(0));
      else check("prod8", 64'(bus8.product), 64'(exp8_q.pop_front()));
    end
  end

  task automatic op4(input vec4_t v);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    bus4.start = 1'b1; bus4.signed_mode = v.sm; bus4.a = v.a; bus4.b = v.b;
    exp4_q.push_back(v.exp);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check("hold4", 64'(bus4.product), 64'(last4));
    cyc = 0;
    busy_cyc = (bus4.busy === 1'b1) ? 1 : 0;
    while (bus4.done !== 1'b1 && cyc < 30) begin
      bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.signed_mode = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (bus4.busy === 1'b1) busy_cyc++;
    end
    check("lat4", 64'(cyc), 64'(5));
    check("busy4_cycles", 64'(busy_cyc), 64'(5));
    @(posedge clk); #1;
    check("done4_pulse", 64'(bus4.done), 64'(0));
    last4 = v.exp;
  endtask

  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input bit poke);
    int cyc;
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = sm; bus8.a = a; bus8.b = b;
    exp8_q.push_back(exp);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("hold8", 64'(bus8.product), 64'(last8));
    cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus8.start = (poke && (cyc == 2 || cyc == 5)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus8.start = 1'b0;
    check("lat8", 64'(cyc), 64'(9));
    check("busy8_fall", 64'(bus8.busy), 64'(0));
    last8 = exp;
  endtask

  initial begin
    int cyc;
    int d0;
    v4[0] = '{1'b0, 4'd3,  4'd5,  8'd15};
    v4[1] = '{1'b0, 4'd15, 4'd15, 8'd225};
    v4[2] = '{1'b0, 4'd7,  4'd9,  8'd63};
    v4[3] = '{1'b0, 4'd2,  4'd8,  8'd16};
    v4[4] = '{1'b0, 4'd0,  4'd13, 8'd0};
    v4[5] = '{1'b1, 4'h8,  4'h8,  8'h40};
    v4[6] = '{1'b1, 4'h8,  4'h7,  8'hC8};
    v4[7] = '{1'b1, 4'h3,  4'hB,  8'hF1};
    v4[8] = '{1'b1, 4'hF,  4'hF,  8'h01};

    bus4.start = 0; bus4.signed_mode = 0; bus4.a = 0; bus4.b = 0;
    bus8.start = 0; bus8.signed_mode = 0; bus8.a = 0; bus8.b = 0;
    repeat (3) @(negedge clk);
    check("rst_busy4", 64'(bus4.busy), 64'(0));
    check("rst_done4", 64'(bus4.done), 64'(0));
    check("rst_prod4", 64'(bus4.product), 64'(0));
    check("rst_busy8", 64'(bus8.busy), 64'(0));
    check("rst_prod8", 64'(bus8.product), 64'(0));
    check("rst_state8", 64'(st8), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) op4(v4[i]);

    op8(1'b0, 8'd255, 8'd255, 16'd65025, 1'b1);

    // Back-to-back: start held in the done cycle must be taken with no idle gap.
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.a = 8'd100; bus8.b = 8'hFD;
    exp8_q.push_back(16'hFED4);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat8_first", 64'(cyc), 64'(9));
    bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.a = 8'h7F; bus8.b = 8'h80;
    exp8_q.push_back(16'hC080);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("b2b_busy", 64'(bus8.busy), 64'(1));
    check("b2b_done_drop", 64'(bus8.done), 64'(0));
    check("b2b_hold", 64'(bus8.product), 64'(16'hFED4));
    cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check("lat8_b2b", 64'(cyc), 64'(9));
    last8 = 16'hC080;

    // Reset three cycles into an operation: outputs clear at once, no done follows.
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = 1'b0; bus8.a = 8'd200; bus8.b = 8'd3;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy8", 64'(bus8.busy), 64'(0));
    check("arst_done8", 64'(bus8.done), 64'(0));
    check("arst_prod8", 64'(bus8.product), 64'(0));
    check("arst_prod4", 64'(bus4.product), 64'(0));
    last8 = '0;
    last4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done8_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'(done8_cnt), 64'(d0));

    op8(1'b0, 8'd12, 8'd10, 16'd120, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("done4_total", 64'(done4_cnt), 64'(9));
    check("done8_total", 64'(done8_cnt), 64'(4));
    check("q4_empty", 64'(exp4_q.size()), 64'(0));
    check("q8_empty", 64'(exp8_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
